// File: rtl/enemy_map_pkg.sv
// enemy_map_pkg: shared defaults, FSM state type and round-robin helper for the enemy map write arbiter
package enemy_map_pkg;
    localparam int DEF_DATA_WIDTH = 3;
    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAP_CELLS  = 192;
    localparam int SWEEP_W        = 8;

    typedef enum logic [1:0] {IDLE, GRANT, CLEAR} map_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/enemy_map_write_arbiter_if.sv
// enemy_map_write_arbiter_if: requester, clear-control and map RAM write-port signals of the arbiter
interface enemy_map_write_arbiter_if import enemy_map_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          clear_start;
    logic                          clear_busy;
    logic                          clear_done;
    logic                          ram_we;
    logic [ADDR_WIDTH-1:0]         ram_write;
    logic [DATA_WIDTH-1:0]         ram_data;
    logic                          addr_err;

    modport master (
        output req, req_addr, req_data, clear_start,
        input  gnt, clear_busy, clear_done, ram_we, ram_write, ram_data, addr_err
    );

    modport slave (
        input  req, req_addr, req_data, clear_start,
        output gnt, clear_busy, clear_done, ram_we, ram_write, ram_data, addr_err
    );
endinterface

// File: rtl/enemy_map_rr_arb.sv
// enemy_map_rr_arb: combinational round-robin pick, search starts at ptr and wraps to 0
module enemy_map_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PTR_W-1:0]   win_idx,
    output logic               any
);
    always_comb begin
        int idx;
        idx     = 0;
        win     = '0;
        win_idx = '0;
        any     = |req;
        // walk from farthest to nearest so the nearest requester after ptr wins
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            if (req[idx]) begin
                win      = '0;
                win[idx] = 1'b1;
                win_idx  = PTR_W'(idx);
            end
        end
    end
endmodule

// File: rtl/enemy_map_write_arbiter.sv
// enemy_map_write_arbiter: round-robin map RAM write arbiter with a full-map clear sweep
// Optional ENEMY_MAP_ADDR_CHECK_EN: out-of-range winners are granted but not written, and set sticky addr_err.
module enemy_map_write_arbiter import enemy_map_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAP_CELLS  = DEF_MAP_CELLS
) (
    input logic                    write_clk,
    input logic                    rst_n,
    enemy_map_write_arbiter_if.slave bus
);
    localparam int                 PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [SWEEP_W-1:0] LAST_CELL = SWEEP_W'(MAP_CELLS - 1);

    map_state_e            state, state_nxt;
    logic [SWEEP_W-1:0]    cnt, cnt_nxt;
    logic [PTR_W-1:0]      ptr, ptr_nxt, win_idx;
    logic [NUM_REQ-1:0]    win, gnt_q, gnt_nxt;
    logic                  any, wr_ok;
    logic                  we_q, we_nxt, busy_q, busy_nxt, done_q, done_nxt, err_q, err_nxt;
    logic [ADDR_WIDTH-1:0] wr_q, wr_nxt, w_addr;
    logic [DATA_WIDTH-1:0] dat_q, dat_nxt, w_data;

    // the requester just granted still holds req this cycle; mask it to avoid a double grant
    enemy_map_rr_arb #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req    (bus.req & ~gnt_q),
        .ptr    (ptr),
        .win    (win),
        .win_idx(win_idx),
        .any    (any)
    );

    assign w_addr = bus.req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_data = bus.req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

`ifdef ENEMY_MAP_ADDR_CHECK_EN
    assign wr_ok = w_addr < ADDR_WIDTH'(MAP_CELLS);
`else
    assign wr_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gnt_nxt   = '0;
        we_nxt    = 1'b0;
        wr_nxt    = wr_q;
        dat_nxt   = dat_q;
        busy_nxt  = 1'b0;
        done_nxt  = busy_q && state != CLEAR;
        err_nxt   = err_q;
        if (state == CLEAR) begin
            we_nxt    = 1'b1;
            wr_nxt    = ADDR_WIDTH'(cnt);
            dat_nxt   = '0;
            busy_nxt  = 1'b1;
            cnt_nxt   = (cnt == LAST_CELL) ? '0 : cnt + 1'b1;
            state_nxt = (cnt == LAST_CELL) ? IDLE : CLEAR;
        end else if (bus.clear_start) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
        end else begin
            state_nxt = any ? GRANT : IDLE;
            if (any) begin
                gnt_nxt = win;
                ptr_nxt = PTR_W'(rr_next(int'(win_idx), NUM_REQ));
                we_nxt  = wr_ok;
                wr_nxt  = wr_ok ? w_addr : wr_q;
                dat_nxt = wr_ok ? w_data : dat_q;
                err_nxt = err_q | ~wr_ok;
            end
        end
    end

    always_ff @(posedge write_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge write_clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            ptr    <= '0;
            gnt_q  <= '0;
            we_q   <= 1'b0;
            wr_q   <= '0;
            dat_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            ptr    <= ptr_nxt;
            gnt_q  <= gnt_nxt;
            we_q   <= we_nxt;
            wr_q   <= wr_nxt;
            dat_q  <= dat_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.ram_we     = we_q;
    assign bus.ram_write  = wr_q;
    assign bus.ram_data   = dat_q;
    assign bus.clear_busy = busy_q;
    assign bus.clear_done = done_q;
    assign bus.addr_err   = err_q;
endmodule

// File: tb/tb_enemy_map_write_arbiter.sv
// tb_enemy_map_write_arbiter: directed vectors with hand-computed expectations for the map write arbiter
module tb_enemy_map_write_arbiter;
    import enemy_map_pkg::*;

    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;

    logic write_clk = 1'b0;
    logic rst_n     = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    enemy_map_write_arbiter_if bus ();

    enemy_map_write_arbiter dut (
        .write_clk(write_clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #5 write_clk = ~write_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge write_clk);
        #1;
    endtask

    task automatic set_slot(input int i, input int a, input int d);
        bus.req_addr[i*AW +: AW] = AW'(a);
        bus.req_data[i*DW +: DW] = DW'(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        bad             = 0;
        bus.req         = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.clear_start = 1'b0;
        rst_n           = 1'b0;
        tick(2);
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_we", 32'(bus.ram_we), 0);
        check("rst_addr", 32'(bus.ram_write), 0);
        check("rst_data", 32'(bus.ram_data), 0);
        check("rst_busy", 32'(bus.clear_busy), 0);
        check("rst_done", 32'(bus.clear_done), 0);
        check("rst_err", 32'(bus.addr_err), 0);

        // single request, one-cycle latency, then idle with held address
        rst_n = 1'b1;
        set_slot(0, 5, 3);
        bus.req = 4'b0001;
        tick();
        check("single_gnt", 32'(bus.gnt), 1);
        check("single_we", 32'(bus.ram_we), 1);
        check("single_addr", 32'(bus.ram_write), 5);
        check("single_data", 32'(bus.ram_data), 3);
        bus.req = '0;
        tick();
        check("single_gnt_off", 32'(bus.gnt), 0);
        check("single_we_off", 32'(bus.ram_we), 0);
        check("single_addr_hold", 32'(bus.ram_write), 5);

        // round robin from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_slot(i, 10 + i, i + 1);
        bus.req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("rr_gnt%0d", c), 32'(bus.gnt), 32'(1 << (c % 4)));
            check($sformatf("rr_addr%0d", c), 32'(bus.ram_write), 32'(10 + c % 4));
        end
        bus.req = '0;
        tick();
        check("rr_idle_gnt", 32'(bus.gnt), 0);
        check("rr_idle_we", 32'(bus.ram_we), 0);

        // clear wins over a same-cycle request; a second clear_start mid-sweep is ignored
        set_slot(1, 77, 6);
        bus.req = 4'b0010;
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        check("clr_entry_gnt", 32'(bus.gnt), 0);
        check("clr_entry_we", 32'(bus.ram_we), 0);
        for (int k = 0; k < 192; k++) begin
            if (k == 50) bus.clear_start = 1'b1;
            tick();
            bus.clear_start = 1'b0;
            if (bus.ram_we !== 1'b1 || bus.ram_write !== AW'(k) || bus.ram_data !== '0 ||
                bus.clear_busy !== 1'b1 || bus.gnt !== '0 || bus.clear_done !== 1'b0) bad++;
        end
        check("clr_sweep_bad_cycles", 32'(bad), 0);
        tick();
        check("clr_done", 32'(bus.clear_done), 1);
        check("clr_busy_off", 32'(bus.clear_busy), 0);
        check("clr_pending_gnt", 32'(bus.gnt), 2);
        check("clr_pending_addr", 32'(bus.ram_write), 77);
        check("clr_pending_data", 32'(bus.ram_data), 6);
        bus.req = '0;
        tick();
        check("clr_done_pulse", 32'(bus.clear_done), 0);
        check("clr_after_we", 32'(bus.ram_we), 0);

        // reset in the middle of a sweep
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        tick(101);
        check("abort_addr", 32'(bus.ram_write), 100);
        check("abort_busy", 32'(bus.clear_busy), 1);
        rst_n = 1'b0;
        tick();
        check("abort_we", 32'(bus.ram_we), 0);
        check("abort_addr0", 32'(bus.ram_write), 0);
        check("abort_busy0", 32'(bus.clear_busy), 0);
        check("abort_done0", 32'(bus.clear_done), 0);
        check("abort_gnt0", 32'(bus.gnt), 0);
        rst_n = 1'b1;
        set_slot(2, 150, 4);
        bus.req = 4'b0100;
        tick();
        check("abort_no_done", 32'(bus.clear_done), 0);
        check("abort_idle_gnt", 32'(bus.gnt), 4);
        check("abort_idle_addr", 32'(bus.ram_write), 150);
        bus.req = '0;
        tick();

        // last valid cell
        set_slot(0, 191, 2);
        bus.req = 4'b0001;
        tick();
        check("edge191_gnt", 32'(bus.gnt), 1);
        check("edge191_we", 32'(bus.ram_we), 1);
        check("edge191_addr", 32'(bus.ram_write), 191);
        bus.req = '0;
        tick();

        // out-of-range cell
        set_slot(0, 200, 5);
        bus.req = 4'b0001;
        tick();
        check("oor_gnt", 32'(bus.gnt), 1);
`ifdef ENEMY_MAP_ADDR_CHECK_EN
        check("oor_we", 32'(bus.ram_we), 0);
        check("oor_addr_hold", 32'(bus.ram_write), 191);
        check("oor_err", 32'(bus.addr_err), 1);
`else
        check("oor_we", 32'(bus.ram_we), 1);
        check("oor_addr", 32'(bus.ram_write), 200);
        check("oor_err", 32'(bus.addr_err), 0);
`endif
        bus.req = '0;
        tick();
`ifdef ENEMY_MAP_ADDR_CHECK_EN
        check("oor_err_sticky", 32'(bus.addr_err), 1);
`else
        check("oor_err_sticky", 32'(bus.addr_err), 0);
`endif
        rst_n = 1'b0;
        tick();
        check("oor_err_rst", 32'(bus.addr_err), 0);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/enemy_map_write_arbiter.md
ENEMY_MAP_WRITE_ARBITER -- requirements
Module: enemy_map_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3, map cell code width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 15, map RAM address width.
REQ-003 SHALL have parameter NUM_REQ, default 4, number of write requesters (enemy tank movers, bullet-hit clear, level loader).
REQ-004 SHALL have parameter MAP_CELLS, default 192, number of valid map cells.
REQ-005 SHALL have port write_clk  input  1  single clock, same clock as the map RAM write port.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester write request, level, held until granted.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  packed cell addresses, requester i at slice i.
REQ-009 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed cell codes, requester i at slice i.
REQ-010 SHALL have port gnt  output  NUM_REQ  one-hot grant pulse, one cycle.
REQ-011 SHALL have port clear_start  input  1  pulse, wipe the whole map to code 0.
REQ-012 SHALL have port clear_busy  output  1  high while a clear sweep runs.
REQ-013 SHALL have port clear_done  output  1  one-cycle pulse after the last clear write.
REQ-014 SHALL have ports ram_we (1), ram_write (ADDR_WIDTH), ram_data (DATA_WIDTH), outputs driving the map RAM write port.
REQ-015 SHALL have port addr_err  output  1  sticky out-of-range address flag.

Function
REQ-016 SHALL implement states IDLE, GRANT, CLEAR.
REQ-017 IDLE: any req high -> GRANT; clear_start -> CLEAR; clear_start has priority over req in the same cycle.
REQ-018 GRANT: exactly one requester served per cycle; the winner, sampled at cycle N, gets gnt and ram_we with its addr/data, registered, at cycle N+1.
REQ-019 Arbitration SHALL be round-robin: search starts at the index after the last granted requester and wraps from NUM_REQ-1 to 0; pointer is 0 after reset.
REQ-020 The requester SHALL deassert req, or present a new transaction, in the cycle after gnt; back-to-back grants to different requesters SHALL sustain one write per cycle.
REQ-021 GRANT -> IDLE when no req is high; GRANT -> CLEAR on clear_start, with no grant issued in that cycle.
REQ-022 CLEAR: writes code 0 to addresses 0..MAP_CELLS-1 ascending, one per cycle, ram_we high for all MAP_CELLS cycles; clear_busy high throughout; gnt held 0.
REQ-023 clear_start while in CLEAR SHALL be ignored; no restart.
REQ-024 After address MAP_CELLS-1 is written, clear_done SHALL pulse for one cycle and the state SHALL return to IDLE; requests pending during the clear are served afterwards in round-robin order.
REQ-025 ram_we SHALL be low whenever no grant and no clear write occurs; ram_write and ram_data hold their last value when ram_we is low.

Reset
REQ-026 On write_clk with rst_n low: state IDLE, pointer 0, gnt 0, ram_we 0, ram_write 0, ram_data 0, clear_busy 0, clear_done 0, addr_err 0.
REQ-027 Reset during CLEAR SHALL abort the sweep with no clear_done pulse; the map is left partially cleared.

Configuration
REQ-028 Macro ENEMY_MAP_ADDR_CHECK_EN defined: a winning request with addr >= MAP_CELLS SHALL still receive gnt, SHALL NOT assert ram_we, and SHALL set addr_err until reset.
REQ-029 Macro ENEMY_MAP_ADDR_CHECK_EN undefined: no range check; every grant writes; addr_err is tied 0.

Structure
REQ-030 Package enemy_map_pkg SHALL hold the DATA_WIDTH, ADDR_WIDTH, MAP_CELLS, and NUM_REQ defaults and the state enum typedef.
REQ-031 Round-robin selection SHALL be the sub-module enemy_map_rr_arb: req vector and pointer in, one-hot winner out, combinational.
REQ-032 The sweep counter SHALL be 8 bits wide, compared against MAP_CELLS-1.

Verification
REQ-033 Reset, then req=4'b0001, addr 5, data 3 -> gnt=0001 and ram_we, ram_write=5, ram_data=3 exactly one cycle later; ram_we then 0.
REQ-034 req=4'b1111 held for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001 ...; each index is granted once per 4 cycles.
REQ-035 clear_start with req=4'b0010 in the same cycle -> 192 writes of data 0 at addresses 0..191; clear_done pulses once; then gnt=0010.
REQ-036 rst_n low at sweep address 100 -> all outputs 0 next cycle; no clear_done pulse; state IDLE.
REQ-037 With ENEMY_MAP_ADDR_CHECK_EN, req addr 200 -> gnt pulses, ram_we stays 0, addr_err=1 until reset; without the macro, ram_we=1 and ram_write=200.
